// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the matrix multiplier sequencer.
// Holds the FSM state enum, the C width rule and flat-index helpers.
package matrix_mult_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DRAIN
   } mm_state_e;

   // Product of two DW-bit values summed K times.
   function automatic int c_data_width(input int dw, input int k);
      return 2 * dw + $clog2(k);
   endfunction

   // Row-major flat element index.
   function automatic int flat_idx(input int row, input int col,
                                   input int ncols);
      return row * ncols + col;
   endfunction

   // Bit offset of a row-major element of width w.
   function automatic int flat_bit(input int row, input int col,
                                   input int ncols, input int w);
      return flat_idx(row, col, ncols) * w;
   endfunction

endpackage

// File: rtl/matrix_mult_idx_counter.sv
// Index counter with enable and explicit terminal-count wrap.
// Ports: clk_i, reset_ni, en_i (advance), idx_o (index), last_o (at COUNT-1).
module matrix_mult_idx_counter #(
   parameter int unsigned COUNT = 52,
   localparam int unsigned W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic         en_i,
   output logic [W-1:0] idx_o,
   output logic         last_o
);

   localparam logic [W-1:0] IDX_LAST = W'(COUNT - 1);

   assign last_o = (idx_o == IDX_LAST);

   // Wrap on the terminal compare, not on the power-of-2 rollover.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx_o <= '0;
      end else if (en_i) begin
         idx_o <= last_o ? '0 : idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Sequencer: loads A/B from a serial stream, fires the multiplier, drains C.
// Ports: in_* operand stream, mm_* datapath side, out_* result stream, busy_o.
module matrix_mult_sequencer
   import matrix_mult_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int A_ROWS           = 8,
   parameter int B_COLUMNS        = 5,
   parameter int A_COLUMNS_B_ROWS = 4,
   localparam int C_DATA_WIDTH    = c_data_width(DATA_WIDTH, A_COLUMNS_B_ROWS)
) (
   input  logic                                          clk_i,
   input  logic                                          reset_ni,
   input  logic [DATA_WIDTH-1:0]                         in_data_i,
   input  logic                                          in_valid_i,
   output logic                                          in_ready_o,
   output logic [A_ROWS*A_COLUMNS_B_ROWS*DATA_WIDTH-1:0] mm_a_o,
   output logic [A_COLUMNS_B_ROWS*B_COLUMNS*DATA_WIDTH-1:0] mm_b_o,
   output logic                                          mm_valid_o,
   input  logic                                          mm_valid_i,
   input  logic [A_ROWS*B_COLUMNS*C_DATA_WIDTH-1:0]      mm_c_i,
   output logic [C_DATA_WIDTH-1:0]                       out_data_o,
   output logic                                          out_valid_o,
   output logic                                          out_last_o,
   input  logic                                          out_ready_i,
   output logic                                          busy_o
);

   localparam int K  = A_COLUMNS_B_ROWS;
   localparam int DW = DATA_WIDTH;
   localparam int CW = C_DATA_WIDTH;
   localparam int NA = A_ROWS * K;
   localparam int NB = K * B_COLUMNS;
   localparam int NC = A_ROWS * B_COLUMNS;
   localparam int LW = (NA + NB > 1) ? $clog2(NA + NB) : 1;
   localparam int OW = (NC > 1) ? $clog2(NC) : 1;

   mm_state_e state_q;

   logic          in_ready_q;
   logic          mm_valid_q;
   logic          out_valid_q;
   logic [LW-1:0] load_idx;
   logic          load_last;
   logic [OW-1:0] out_idx;
   logic          out_last;
   logic          load_en;
   logic          drain_en;

   logic [NA*DW-1:0] a_q;
   logic [NB*DW-1:0] b_q;
   logic [NC*CW-1:0] c_q;

   assign load_en  = in_valid_i & in_ready_q;
   assign drain_en = out_valid_q & out_ready_i;

   matrix_mult_idx_counter #(
      .COUNT (NA + NB)
   ) u_load_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (load_en),
      .idx_o    (load_idx),
      .last_o   (load_last)
   );

   matrix_mult_idx_counter #(
      .COUNT (NC)
   ) u_drain_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (drain_en),
      .idx_o    (out_idx),
      .last_o   (out_last)
   );

   // Outputs are decoded on the transition so they leave the flops directly.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_LOAD;
         in_ready_q  <= 1'b1;
         mm_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (load_en && load_last) begin
                  state_q    <= ST_START;
                  in_ready_q <= 1'b0;
                  mm_valid_q <= 1'b1;
               end
            end
            ST_START: begin
               state_q    <= ST_WAIT;
               mm_valid_q <= 1'b0;
            end
            ST_WAIT: begin
               if (mm_valid_i) begin
                  state_q     <= ST_DRAIN;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_en && out_last) begin
                  state_q     <= ST_LOAD;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_LOAD;
               in_ready_q  <= 1'b1;
               mm_valid_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Banks only write in LOAD / WAIT, so they stay frozen elsewhere.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else begin
         if (load_en) begin
            for (int i = 0; i < NA; i++) begin
               if (load_idx == LW'(i)) a_q[i*DW +: DW] <= in_data_i;
            end
            for (int j = 0; j < NB; j++) begin
               if (load_idx == LW'(NA + j)) b_q[j*DW +: DW] <= in_data_i;
            end
         end
         if (state_q == ST_WAIT && mm_valid_i) begin
            c_q <= mm_c_i;
         end
      end
   end

   always_comb begin
      out_data_o = '0;
      for (int i = 0; i < NC; i++) begin
         if (out_valid_q && out_idx == OW'(i)) begin
            out_data_o = c_q[i*CW +: CW];
         end
      end
   end

   assign in_ready_o  = in_ready_q;
   assign mm_valid_o  = mm_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_valid_q & out_last;
   assign mm_a_o      = a_q;
   assign mm_b_o      = b_q;
   assign busy_o      = !(state_q == ST_LOAD && load_idx == '0);

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed and randomized bench for matrix_mult_sequencer.
// The bench plays both host and multiplier datapath, using its own C model.
module tb_matrix_mult_sequencer;

   localparam int DW = 8;
   localparam int AR = 8;
   localparam int BC = 5;
   localparam int K  = 4;
   localparam int CW = 2 * DW + $clog2(K);
   localparam int NA = AR * K;
   localparam int NB = K * BC;
   localparam int NC = AR * BC;

   logic                clk = 1'b0;
   logic                reset_ni;
   logic [DW-1:0]       in_data;
   logic                in_valid;
   logic                in_ready;
   logic [NA*DW-1:0]    mm_a;
   logic [NB*DW-1:0]    mm_b;
   logic                mm_valid_o;
   logic                mm_valid_i;
   logic [NC*CW-1:0]    mm_c;
   logic [CW-1:0]       out_data;
   logic                out_valid;
   logic                out_last;
   logic                out_ready;
   logic                busy;

   int checks = 0;
   int errors = 0;

   int a_m [AR][K];
   int b_m [K][BC];
   int c_m [AR][BC];
   logic [NA*DW-1:0] exp_a;
   logic [NB*DW-1:0] exp_b;
   logic [NC*CW-1:0] exp_c;

   always #5 clk = ~clk;

   matrix_mult_sequencer #(
      .DATA_WIDTH       (DW),
      .A_ROWS           (AR),
      .B_COLUMNS        (BC),
      .A_COLUMNS_B_ROWS (K)
   ) dut (
      .clk_i       (clk),
      .reset_ni    (reset_ni),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .mm_a_o      (mm_a),
      .mm_b_o      (mm_b),
      .mm_valid_o  (mm_valid_o),
      .mm_valid_i  (mm_valid_i),
      .mm_c_i      (mm_c),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .out_ready_i (out_ready),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage_c();
      for (int w = 0; w < NC; w++) mm_c[w*CW +: CW] = CW'($urandom);
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < AR; i++)
         for (int k = 0; k < K; k++)
            case (mode)
               0: a_m[i][k] = 1;
               1: a_m[i][k] = 255;
               2: a_m[i][k] = i + k;
               default: a_m[i][k] = int'($urandom_range(0, 255));
            endcase
      for (int k = 0; k < K; k++)
         for (int j = 0; j < BC; j++)
            case (mode)
               0: b_m[k][j] = 1;
               1: b_m[k][j] = 255;
               2: b_m[k][j] = (k == j) ? 1 : 0;
               default: b_m[k][j] = int'($urandom_range(0, 255));
            endcase
      for (int i = 0; i < AR; i++)
         for (int j = 0; j < BC; j++) begin
            c_m[i][j] = 0;
            for (int k = 0; k < K; k++) c_m[i][j] += a_m[i][k] * b_m[k][j];
            exp_c[(i*BC+j)*CW +: CW] = CW'(c_m[i][j]);
         end
      for (int i = 0; i < AR; i++)
         for (int k = 0; k < K; k++)
            exp_a[(i*K+k)*DW +: DW] = DW'(a_m[i][k]);
      for (int k = 0; k < K; k++)
         for (int j = 0; j < BC; j++)
            exp_b[(k*BC+j)*DW +: DW] = DW'(b_m[k][j]);
   endtask

   function automatic int elem(input int idx);
      if (idx < NA) return a_m[idx/K][idx%K];
      return b_m[(idx-NA)/BC][(idx-NA)%BC];
   endfunction

   // Feed idx_lo..idx_hi-1 of the operand stream.
   task automatic feed(input int idx_lo, input int idx_hi, input bit gaps);
      for (int idx = idx_lo; idx < idx_hi; idx++) begin
         while (gaps && ($urandom % 2) == 1) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            tick();
            chk("gap_ready", in_ready, 1);
            chk("gap_busy", busy, (idx != 0));
         end
         in_valid = 1'b1;
         in_data  = DW'(elem(idx));
         chk("load_ready", in_ready, 1);
         tick();
      end
   endtask

   task automatic run_job(input int mode, input bit gaps, input bit stall,
                          input bit hold, input int wait_extra,
                          input int stop_at);
      int cnt;
      int guard;
      bit rdy;
      fill(mode);
      if (hold) begin
         in_valid   = 1'b0;
         mm_valid_i = 1'b1;
         garbage_c();
         tick();
         mm_valid_i = 1'b0;
         chk("glitch_mmv", mm_valid_o, 0);
         chk("glitch_outv", out_valid, 0);
         chk("glitch_ready", in_ready, 1);
         chk("glitch_busy", busy, 0);
      end
      feed(0, NA + NB, gaps);
      in_valid = hold;
      in_data  = DW'($urandom);
      chk("start_mmv", mm_valid_o, 1);
      chk("start_ready", in_ready, 0);
      chk("start_busy", busy, 1);
      chk("start_a", mm_a, exp_a);
      chk("start_b", mm_b, exp_b);
      tick();
      chk("wait_mmv", mm_valid_o, 0);
      chk("wait_ready", in_ready, 0);
      for (int w = 0; w < wait_extra; w++) begin
         tick();
         chk("wait_outv", out_valid, 0);
      end
      mm_valid_i = 1'b1;
      mm_c       = exp_c;
      tick();
      mm_valid_i = 1'b0;
      garbage_c();
      cnt   = 0;
      guard = 0;
      while (cnt < NC && guard < 400) begin
         if (cnt == stop_at) break;
         rdy       = stall ? 1'($urandom % 2) : 1'b1;
         out_ready = rdy;
         if (hold) begin
            in_valid   = !(rdy && cnt == NC - 1);
            in_data    = DW'($urandom);
            mm_valid_i = 1'($urandom % 2);
         end
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, c_m[cnt/BC][cnt%BC]);
         chk("drain_last", out_last, (cnt == NC - 1));
         chk("drain_mmv", mm_valid_o, 0);
         chk("drain_ready", in_ready, 0);
         chk("drain_a", mm_a, exp_a);
         chk("drain_b", mm_b, exp_b);
         tick();
         if (rdy) cnt++;
         guard++;
      end
      out_ready  = 1'b0;
      in_valid   = 1'b0;
      mm_valid_i = 1'b0;
      if (stop_at < 0) begin
         chk("drain_count", cnt, NC);
         chk("end_outv", out_valid, 0);
         chk("end_busy", busy, 0);
         chk("end_ready", in_ready, 1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_outv"}, out_valid, 0);
      chk({tag, "_mmv"}, mm_valid_o, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_a"}, mm_a, 0);
      chk({tag, "_b"}, mm_b, 0);
   endtask

   task automatic pulse_reset(input string tag);
      #2 reset_ni = 1'b0;
      #1 check_reset_outputs(tag);
      @(negedge clk);
      reset_ni = 1'b1;
      tick();
      chk({tag, "_rel_ready"}, in_ready, 1);
      chk({tag, "_rel_busy"}, busy, 0);
   endtask

   initial begin
      reset_ni   = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      mm_valid_i = 1'b0;
      mm_c       = '0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      @(negedge clk);
      reset_ni = 1'b1;
      tick();
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);

      run_job(0, 0, 0, 0, 0, -1);
      chk("ones_c", c_m[0][0], 4);
      run_job(1, 0, 0, 0, 0, -1);
      chk("max_c", c_m[7][4], 260100);
      run_job(2, 0, 0, 0, 1, -1);
      for (int r = 0; r < 3; r++) run_job(3, 1, 1, 0, r * 2, -1);

      fill(3);
      feed(0, 20, 1'b0);
      in_valid = 1'b0;
      chk("part_busy", busy, 1);
      repeat (3) tick();
      chk("part_hold_busy", busy, 1);
      pulse_reset("rst_load");
      run_job(3, 0, 1, 0, 0, -1);

      run_job(3, 0, 1, 0, 0, 17);
      chk("mid_drain_outv", out_valid, 1);
      pulse_reset("rst_drain");
      run_job(3, 1, 1, 0, 0, -1);

      run_job(3, 0, 1, 1, 2, -1);
      run_job(0, 1, 1, 1, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
